lab3_vector_sequencer: RTL and testbench
========================================

// Module: lab3_vector_sequencer
// PURPOSE
//  Upstream stimulus and checker stage for the a/b/c -> x/y gate network.
//  On start, it walks all 8 input vectors {a,b,c} = 3'b000..3'b111 into the network.
//  For each vector it holds the inputs for DWELL cycles, then samples x/y and
//  compares them against the golden function. It reports a per-vector failure
//  mask, an error count and a pass/done summary. Used for on-board self-test of
//  the lab gate network.
// PARAMETERS
//  DWELL  4  cycles each vector is held before x/y are sampled; legal range >=1
//  ERR_W  4  width of err_count; the count saturates at 2**ERR_W-1
// PORTS
//  clk        in   1      single system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      single-cycle request to begin or restart a sweep
//  pause      in   1      while high, freezes the sweep (the dwell count is held)
//  a,b,c      out  1 each stimulus to the gate network; {a,b,c} = vec_idx
//  x_in,y_in  in   1 each network outputs; the network is purely combinational
//  vec_idx    out  3      index of the vector currently applied
//  busy       out  1      high while a sweep is in progress
//  done       out  1      high once a sweep completes; held until next start
//  pass       out  1      valid when done=1; equals (err_count==0)
//  err_count  out  ERR_W  number of failing vectors, saturating
//  err_mask   out  8      bit i set = vector i failed
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; a=b=c=0; vec_idx=0; busy=0; done=0;
//   pass=0; err_count=0; err_mask=0; dwell counter=0.
//   Reset applies immediately, including in the middle of a sweep.
//   After rst deasserts, the block waits in IDLE for start.
//  Golden function: exp_x = ~(a^b); exp_y = (a|b)&c.
//  A vector fails if x_in!=exp_x or y_in!=exp_y; each vector is counted at most once.
//  States:
//   IDLE -> RUN when start=1. On that edge: vec_idx=0, dwell=0, err_count=0,
//    err_mask=0, busy=1, done=0.
//   RUN: a/b/c are driven from vec_idx combinationally from registered vec_idx.
//    - On each edge with pause=0: dwell increments.
//    - When dwell==DWELL-1: sample x_in/y_in and update err_mask[vec_idx] and
//      err_count; set dwell=0.
//    - After that sample, if vec_idx==7 go to DONE; otherwise vec_idx++.
//    - While pause=1, all registers hold.
//   DONE: busy=0; done=1; pass=(err_count==0); a/b/c hold 3'b111.
//    start=1 clears the results and restarts exactly as from IDLE.
//  Timing: start sampled at edge k with no pause -> done=1 and busy=0
//   after edge k+8*DWELL. Each pause cycle adds one cycle.
//  start is ignored while busy=1.
//  start and pause asserted on the same edge in IDLE: the sweep starts,
//   and the first dwell is paused.
//  err_count stops at 2**ERR_W-1; err_mask is always exact.
//  DWELL=1: each vector is sampled at the end of the cycle it is applied.
// TESTING
//  1 Correct network model, DWELL=4, start pulse -> {a,b,c} steps 000..111,
//    4 cycles each; done=1 at k+32; pass=1; err_count=0; err_mask=8'h00.
//  2 x_in stuck at 0 -> err_mask=8'hC3 (vectors 0,1,6,7); err_count=4; pass=0.
//    y_in stuck at 1 -> err_mask=8'h57; err_count=5.
//  3 pause high for 10 cycles during vector 2 -> vec_idx holds at 2;
//    done=1 at k+42; results identical to scenario 1.
//  4 rst pulse during vector 3 -> all outputs are at their reset values
//    before the next edge; a new start sweeps again from vector 0 and passes.
//  5 start re-pulsed at vector 5 -> ignored, done still at k+32.
//    start in DONE after a failing run -> err_count/err_mask cleared; new sweep begins.
//  6 ERR_W=2, x_in=~exp_x and y_in=~exp_y -> err_mask=8'hFF;
//    err_count=3 (saturated); pass=0.

Source files
------------

// File: rtl/lab3_vector_sequencer_if.sv
// Handshake and stimulus/response bundle between the vector sequencer and the
// gate network under test; the sequencer is the master side.
interface lab3_vector_sequencer_if #(
   parameter int ERR_W = 4
);
   logic             start;
   logic             pause;
   logic             a;
   logic             b;
   logic             c;
   logic             x_in;
   logic             y_in;
   logic [2:0]       vec_idx;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [7:0]       err_mask;

   modport master (
      input  start, pause, x_in, y_in,
      output a, b, c, vec_idx, busy, done, pass, err_count, err_mask
   );

   modport slave (
      output start, pause, x_in, y_in,
      input  a, b, c, vec_idx, busy, done, pass, err_count, err_mask
   );
endinterface

// File: rtl/lab3_vector_sequencer.sv
// On-board self-test sequencer: sweeps {a,b,c} through all 8 vectors, holds each
// for DWELL cycles, then checks x/y against the golden gate function.
module lab3_vector_sequencer #(
   parameter int DWELL = 4,
   parameter int ERR_W = 4
) (
   input logic                     clk,
   input logic                     rst,
   lab3_vector_sequencer_if.master bus
);
   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       vec_q, vec_d;
   logic [DW_W-1:0]  dwell_q, dwell_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;
   logic [7:0]       mask_q, mask_d;
   logic             exp_x, exp_y, vec_fail;

   // Error count sticks at all-ones instead of wrapping back to a passing value.
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         dwell_q <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         dwell_q <= dwell_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      exp_x    = ~(vec_q[2] ^ vec_q[1]);
      exp_y    = (vec_q[2] | vec_q[1]) & vec_q[0];
      vec_fail = (bus.x_in != exp_x) || (bus.y_in != exp_y);

      state_d = state_q;
      vec_d   = vec_q;
      dwell_d = dwell_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = RUN;
               vec_d   = '0;
               dwell_d = '0;
               cnt_d   = '0;
               mask_d  = '0;
            end
         end
         RUN: begin
            // start is ignored mid-sweep; pause freezes every register.
            if (!bus.pause) begin
               if (dwell_q == DWELL_LAST) begin
                  dwell_d = '0;
                  if (vec_fail) begin
                     mask_d[vec_q] = 1'b1;
                     cnt_d         = sat_inc(cnt_q);
                  end
                  if (vec_q == 3'd7) state_d = DONE;
                  else               vec_d   = vec_q + 3'd1;
               end else begin
                  dwell_d = dwell_q + DW_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // vec_idx stays at 7 in DONE, so the network keeps seeing 3'b111.
   assign bus.a         = vec_q[2];
   assign bus.b         = vec_q[1];
   assign bus.c         = vec_q[0];
   assign bus.vec_idx   = vec_q;
   assign bus.busy      = (state_q == RUN);
   assign bus.done      = (state_q == DONE);
   assign bus.pass      = (state_q == DONE) && (cnt_q == '0);
   assign bus.err_count = cnt_q;
   assign bus.err_mask  = mask_q;
endmodule

// File: tb/tb_lab3_vector_sequencer.sv
// Self-checking bench: table of sweeps scored through a queue, plus hand-written
// reset, DWELL=1 and saturation sequences on a second instance.
module tb_lab3_vector_sequencer;
   localparam int DW1 = 4;

   typedef struct {
      int         mode;       // 0 good, 1 x stuck 0, 2 y stuck 1, 3 x/y inverted
      int         pause_at;
      int         pause_len;
      int         restart_at;
      logic [7:0] mask;
      int         cnt;
      logic       pass;
      int         lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   mode = 0;
   int   start_cyc = 0;
   logic done_prev = 1'b0;
   vec_t sb_q[$];
   vec_t tbl[6];

   lab3_vector_sequencer_if #(.ERR_W(4)) if1 ();
   lab3_vector_sequencer_if #(.ERR_W(2)) if2 ();

   lab3_vector_sequencer #(.DWELL(DW1), .ERR_W(4)) dut (.clk(clk), .rst(rst), .bus(if1));
   lab3_vector_sequencer #(.DWELL(1),   .ERR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [1:0] net(input logic a, input logic b, input logic c, input int m);
      logic ex, ey;
      ex = ~(a ^ b);
      ey = (a | b) & c;
      case (m)
         0:       return {ex, ey};
         1:       return {1'b0, ey};
         2:       return {ex, 1'b1};
         default: return {~ex, ~ey};
      endcase
   endfunction

   assign {if1.x_in, if1.y_in} = net(if1.a, if1.b, if1.c, mode);
   assign {if2.x_in, if2.y_in} = net(if2.a, if2.b, if2.c, 3);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_reset(input string nm);
      chk(nm, {if1.a, if1.b, if1.c, if1.vec_idx, if1.busy, if1.done, if1.pass,
               if1.err_count, if1.err_mask}, 32'd0);
   endtask

   // Scoreboard consumer: one expected record per completed sweep.
   always @(negedge clk) begin
      vec_t e;
      if (if1.done && !done_prev) begin
         if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("err_mask", if1.err_mask, e.mask);
            chk("err_count", if1.err_count, e.cnt);
            chk("pass", if1.pass, e.pass);
            chk("latency", cyc - start_cyc, e.lat);
            chk("done_state", {if1.a, if1.b, if1.c, if1.busy}, 4'b1110);
         end
      end
      done_prev = if1.done;
   end

   task automatic run_vec(input vec_t v);
      int guard;
      bit paused, restarted;
      vec_t dummy;
      mode = v.mode;
      @(negedge clk);
      if1.start = 1'b1;
      sb_q.push_back(v);
      @(negedge clk);
      if1.start = 1'b0;
      start_cyc = cyc;
      chk("start_busy", if1.busy, 32'd1);
      chk("start_clear", {if1.done, if1.err_count, if1.err_mask}, 32'd0);
      guard = 0;
      paused = 0;
      restarted = 0;
      while (!if1.done && guard < 200) begin
         if (v.pause_len == 0)
            chk("step", {if1.a, if1.b, if1.c, if1.vec_idx},
                {3'((cyc - start_cyc) / DW1), 3'((cyc - start_cyc) / DW1)});
         if (!paused && v.pause_len > 0 && if1.vec_idx == 3'(v.pause_at)) begin
            if1.pause = 1'b1;
            repeat (v.pause_len) @(negedge clk);
            chk("pause_hold", if1.vec_idx, 3'(v.pause_at));
            if1.pause = 1'b0;
            paused = 1;
            guard += v.pause_len;
         end else begin
            if (!restarted && v.restart_at >= 0 && if1.vec_idx == 3'(v.restart_at)) begin
               if1.start = 1'b1;
               restarted = 1;
            end
            @(negedge clk);
            if1.start = 1'b0;
            guard++;
         end
      end
      if (!if1.done) begin
         chk("timeout", 32'd0, 32'd1);
         if (sb_q.size() > 0) dummy = sb_q.pop_back();
      end
   endtask

   task automatic run2(input bit with_pause);
      @(negedge clk);
      if2.start = 1'b1;
      if2.pause = with_pause;
      @(negedge clk);
      if2.start = 1'b0;
      chk("d1_start", {if2.busy, if2.vec_idx}, 4'b1000);
      if (with_pause) begin
         @(negedge clk);
         chk("d1_first_paused", if2.vec_idx, 32'd0);
         if2.pause = 1'b0;
      end
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk("d1_step", if2.vec_idx, i);
      end
      @(negedge clk);
      chk("d1_done", {if2.done, if2.busy, if2.pass}, 3'b100);
      chk("d1_mask", if2.err_mask, 8'hFF);
      chk("d1_sat_count", if2.err_count, 2'd3);
   endtask

   initial begin
      int g;
      if1.start = 1'b0; if1.pause = 1'b0;
      if2.start = 1'b0; if2.pause = 1'b0;
      tbl[0] = '{0, 0, 0, -1, 8'h00, 0, 1'b1, 32};
      tbl[1] = '{1, 0, 0, -1, 8'hC3, 4, 1'b0, 32};
      tbl[2] = '{2, 0, 0, -1, 8'h57, 5, 1'b0, 32};
      tbl[3] = '{3, 0, 0, -1, 8'hFF, 8, 1'b0, 32};
      tbl[4] = '{0, 2, 10, -1, 8'h00, 0, 1'b1, 42};
      tbl[5] = '{0, 0, 0, 5, 8'h00, 0, 1'b1, 32};

      repeat (2) @(negedge clk);
      check_reset("reset_state");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("idle_wait");

      for (int i = 0; i < 6; i++) run_vec(tbl[i]);

      // Asynchronous reset in the middle of vector 3 of a failing sweep.
      mode = 1;
      @(negedge clk);
      if1.start = 1'b1;
      @(negedge clk);
      if1.start = 1'b0;
      g = 0;
      while (if1.vec_idx != 3'd3 && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("pre_rst", {if1.busy, if1.err_count, if1.err_mask}, {1'b1, 4'd2, 8'h03});
      #2 rst = 1'b1;
      #1 check_reset("async_rst");
      @(negedge clk);
      check_reset("rst_held");
      rst = 1'b0;
      run_vec(tbl[0]);

      run2(1'b0);
      run2(1'b1);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
